// File: rtl/board_pkg.sv
// Board types, figure codes, FSM states and start position.
// Square index is {row[5:3], col[2:0]}; row 0 is the black back rank.
package board_pkg;

  typedef logic [3:0] fig_code_t;

  localparam fig_code_t EMPTY   = 4'h0;
  localparam fig_code_t P_WHITE = 4'h1;
  localparam fig_code_t N_WHITE = 4'h2;
  localparam fig_code_t B_WHITE = 4'h3;
  localparam fig_code_t R_WHITE = 4'h4;
  localparam fig_code_t Q_WHITE = 4'h5;
  localparam fig_code_t K_WHITE = 4'h6;
  localparam fig_code_t P_BLACK = 4'h9;
  localparam fig_code_t N_BLACK = 4'hA;
  localparam fig_code_t B_BLACK = 4'hB;
  localparam fig_code_t R_BLACK = 4'hC;
  localparam fig_code_t Q_BLACK = 4'hD;
  localparam fig_code_t K_BLACK = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    COMMIT
  } board_state_t;

  localparam fig_code_t INIT_BOARD [64] = '{
    R_BLACK, N_BLACK, B_BLACK, Q_BLACK,
    K_BLACK, B_BLACK, N_BLACK, R_BLACK,
    P_BLACK, P_BLACK, P_BLACK, P_BLACK,
    P_BLACK, P_BLACK, P_BLACK, P_BLACK,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    P_WHITE, P_WHITE, P_WHITE, P_WHITE,
    P_WHITE, P_WHITE, P_WHITE, P_WHITE,
    R_WHITE, N_WHITE, B_WHITE, Q_WHITE,
    K_WHITE, B_WHITE, N_WHITE, R_WHITE
  };

endpackage

// File: rtl/board_ctl_click_sync.sv
// Button synchronizer and rising-edge detector.
// Ports: clk, rst, btn (async level in), click (1-cycle pulse).
module click_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic click
);

  logic s1;
  logic s2;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s2_q  <= 1'b0;
      click <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      s2_q  <= s2;
      click <= s2 & ~s2_q;
    end
  end

endmodule

// File: rtl/board_ctl.sv
// Board state owner: click-driven pick-up/drop moves, vblank-only writes.
// Ports: clk, rst, mouse_xpos/ypos/left, vblank, figure_xy -> figure_code; held, held_xy, held_code, move_done.
module board_ctl
  import board_pkg::*;
#(
  parameter int BOARD_X0 = 256,
  parameter int BOARD_Y0 = 128,
  parameter int SQ_LOG2  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        vblank,
  input  logic [5:0]  figure_xy,
  output logic [3:0]  figure_code,
  output logic        held,
  output logic [5:0]  held_xy,
  output logic [3:0]  held_code,
  output logic        move_done
);

  localparam logic [11:0] X0 = 12'(BOARD_X0);
  localparam logic [11:0] Y0 = 12'(BOARD_Y0);
  localparam logic [11:0] X1 = 12'(BOARD_X0 + (8 << SQ_LOG2));
  localparam logic [11:0] Y1 = 12'(BOARD_Y0 + (8 << SQ_LOG2));

  fig_code_t    board [64];
  board_state_t state, state_n;
  logic         click;
  logic         in_board;
  logic [11:0]  dx, dy;
  logic [5:0]   sq;
  fig_code_t    sq_code;
  logic [5:0]   dst, dst_n;
  logic [5:0]   hxy_n;
  fig_code_t    hc_n;
  logic         held_n, md_n, wr;

  click_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (mouse_left),
    .click (click)
  );

  assign in_board = (mouse_xpos >= X0) && (mouse_xpos < X1)
                 && (mouse_ypos >= Y0) && (mouse_ypos < Y1);
  assign dx      = mouse_xpos - X0;
  assign dy      = mouse_ypos - Y0;
  assign sq      = {3'(dy >> SQ_LOG2), 3'(dx >> SQ_LOG2)};
  assign sq_code = board[sq];

  always_comb begin
    state_n = state;
    held_n  = held;
    hxy_n   = held_xy;
    hc_n    = held_code;
    dst_n   = dst;
    md_n    = 1'b0;
    wr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (click && in_board && sq_code != EMPTY) begin
          hxy_n   = sq;
          hc_n    = sq_code;
          held_n  = 1'b1;
          state_n = HELD;
        end
      end
      HELD: begin
        if (click) begin
          if (!in_board || sq == held_xy) begin
            held_n  = 1'b0;
            state_n = IDLE;
          end else begin
            dst_n   = sq;
            state_n = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (vblank) begin
          wr      = 1'b1;
          md_n    = 1'b1;
          held_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      held        <= 1'b0;
      held_xy     <= '0;
      held_code   <= '0;
      dst         <= '0;
      move_done   <= 1'b0;
      figure_code <= '0;
    end else begin
      state       <= state_n;
      held        <= held_n;
      held_xy     <= hxy_n;
      held_code   <= hc_n;
      dst         <= dst_n;
      move_done   <= md_n;
      figure_code <= board[figure_xy];
    end
  end

  // Source and destination always differ, so both writes land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        board[i] <= INIT_BOARD[i];
      end
    end else if (wr) begin
      board[dst]     <= held_code;
      board[held_xy] <= EMPTY;
    end
  end

endmodule

// File: tb/tb_board_ctl.sv
// Directed bench for board_ctl.
// Drives on negedge, samples on negedge after the active edge.
module tb_board_ctl;

  logic        clk;
  logic        rst;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic        vblank;
  logic [5:0]  figure_xy;
  logic [3:0]  figure_code;
  logic        held;
  logic [5:0]  held_xy;
  logic [3:0]  held_code;
  logic        move_done;

  int errors = 0;
  int checks = 0;
  int md_cnt = 0;

  board_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .mouse_xpos  (mouse_xpos),
    .mouse_ypos  (mouse_ypos),
    .mouse_left  (mouse_left),
    .vblank      (vblank),
    .figure_xy   (figure_xy),
    .figure_code (figure_code),
    .held        (held),
    .held_xy     (held_xy),
    .held_code   (held_code),
    .move_done   (move_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (move_done === 1'b1) md_cnt++;
  end

  function automatic logic [3:0] exp_init(int s);
    logic [3:0] back [8];
    int r;
    int c;
    back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    r = s / 8;
    c = s % 8;
    case (r)
      0: return back[c] | 4'd8;
      1: return 4'd9;
      6: return 4'd1;
      7: return back[c];
      default: return 4'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int s, output logic [3:0] c);
    @(negedge clk);
    figure_xy = 6'(s);
    @(negedge clk);
    c = figure_code;
  endtask

  task automatic click_at(input int x, input int y);
    @(negedge clk);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
    mouse_left = 1'b1;
    repeat (6) @(negedge clk);
    mouse_left = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic sweep_init(input string tag);
    logic [3:0] c;
    for (int s = 0; s < 64; s++) begin
      rd(s, c);
      chk(tag, {28'd0, c}, {28'd0, exp_init(s)});
    end
  endtask

  initial begin
    logic [3:0] c;
    int m0;
    rst        = 1'b1;
    mouse_xpos = '0;
    mouse_ypos = '0;
    mouse_left = 1'b0;
    vblank     = 1'b0;
    figure_xy  = '0;
    repeat (3) @(negedge clk);
    chk("rst_code", {28'd0, figure_code}, 32'd0);
    chk("rst_held", {31'd0, held}, 32'd0);
    chk("rst_md", {31'd0, move_done}, 32'd0);
    rst = 1'b0;

    // 1: start position
    sweep_init("init");
    chk("t1_held", {31'd0, held}, 32'd0);

    // 2: pick up rook at sq 0, drop on sq 16
    click_at(260, 130);
    chk("t2_held", {31'd0, held}, 32'd1);
    chk("t2_hxy", {26'd0, held_xy}, 32'd0);
    chk("t2_hcode", {28'd0, held_code}, 32'hC);
    click_at(260, 300);
    chk("t2_held_commit", {31'd0, held}, 32'd1);
    m0 = md_cnt;
    vblank = 1'b1;
    repeat (6) @(negedge clk);
    vblank = 1'b0;
    chk("t2_md_pulses", 32'(md_cnt - m0), 32'd1);
    chk("t2_held_after", {31'd0, held}, 32'd0);
    rd(0, c);
    chk("t2_sq0", {28'd0, c}, 32'd0);
    rd(16, c);
    chk("t2_sq16", {28'd0, c}, 32'hC);

    // 3: empty click ignored; cancel by clicking off-board
    click_at(300, 325);
    chk("t3_empty_held", {31'd0, held}, 32'd0);
    click_at(330, 130);
    chk("t3_pick", {31'd0, held}, 32'd1);
    chk("t3_hxy", {26'd0, held_xy}, 32'd1);
    chk("t3_hcode", {28'd0, held_code}, 32'hA);
    click_at(10, 10);
    chk("t3_cancel", {31'd0, held}, 32'd0);
    rd(1, c);
    chk("t3_sq1", {28'd0, c}, 32'hA);

    // 4: commit waits for vblank
    click_at(330, 586);
    chk("t4_hxy", {26'd0, held_xy}, 32'd57);
    chk("t4_hcode", {28'd0, held_code}, 32'h2);
    m0 = md_cnt;
    click_at(394, 458);
    repeat (100) @(negedge clk);
    click_at(10, 10);
    click_at(520, 400);
    chk("t4_no_md", 32'(md_cnt - m0), 32'd0);
    chk("t4_still_held", {31'd0, held}, 32'd1);
    rd(42, c);
    chk("t4_sq42_pre", {28'd0, c}, 32'd0);
    @(negedge clk);
    vblank = 1'b1;
    repeat (6) @(negedge clk);
    vblank = 1'b0;
    chk("t4_md_pulses", 32'(md_cnt - m0), 32'd1);
    rd(42, c);
    chk("t4_sq42", {28'd0, c}, 32'h2);
    rd(57, c);
    chk("t4_sq57", {28'd0, c}, 32'd0);

    // 5: reset during COMMIT
    click_at(260, 200);
    click_at(260, 453);
    chk("t5_in_commit", {31'd0, held}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_held", {31'd0, held}, 32'd0);
    chk("t5_hxy", {26'd0, held_xy}, 32'd0);
    chk("t5_hcode", {28'd0, held_code}, 32'd0);
    chk("t5_code", {28'd0, figure_code}, 32'd0);
    chk("t5_md", {31'd0, move_done}, 32'd0);
    rst = 1'b0;
    vblank = 1'b1;
    repeat (4) @(negedge clk);
    vblank = 1'b0;
    chk("t5_held_post", {31'd0, held}, 32'd0);
    sweep_init("t5_board");

    // 6: long press is one click; 1-cycle glitch still clean
    @(negedge clk);
    mouse_xpos = 12'd260;
    mouse_ypos = 12'd130;
    mouse_left = 1'b1;
    repeat (1000) @(negedge clk);
    chk("t6_long_held", {31'd0, held}, 32'd1);
    mouse_left = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_release", {31'd0, held}, 32'd1);
    chk("t6_hcode", {28'd0, held_code}, 32'hC);
    mouse_left = 1'b1;
    @(negedge clk);
    mouse_left = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_glitch", {31'd0, held}, 32'd0);
    rd(0, c);
    chk("t6_sq0", {28'd0, c}, 32'hC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
